mm2s_packet_router: RTL and testbench
=====================================

Name: mm2s_packet_router

Overview:
- Registered, packet-aware successor to the combinational mm2s tdest demux.
- Accepts one AXI-Stream from the MCDMA mm2s master port and routes each whole packet to one of NUM_FIFOS sink FIFOs.
- tdest is sampled once per packet, on its first beat, and held until tlast.
- Packets with an out-of-range tdest are drained and counted, or stall the stream, depending on mode.
- Sits between the MCDMA mm2s port and the per-accelerator input FIFOs.

Parameters:
- AXIS_DATA_WIDTH, 32, input tdata width.
- FIFO_DATA_WIDTH, 32, sink data width; must be <= AXIS_DATA_WIDTH; low bits are taken.
- AXIS_DEST_WIDTH, 4, tdest width.
- NUM_FIFOS, 4, number of sink channels; range 1..2^AXIS_DEST_WIDTH.
- DROP_INVALID, 1, 1 = drain packets with tdest >= NUM_FIFOS; 0 = hold tready low on such packets.
- CNT_WIDTH, 16, width of the drop and packet counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- SRC_AXIS_tdata  in  AXIS_DATA_WIDTH  stream data.
- SRC_AXIS_tdest  in  AXIS_DEST_WIDTH  destination channel.
- SRC_AXIS_tlast  in  1  last beat of packet.
- SRC_AXIS_tvalid  in  1  beat valid.
- SRC_AXIS_tready  out  1  beat accepted when tvalid && tready.
- fifo_wren  out  NUM_FIFOS  per-channel write enable.
- fifo_full  in  NUM_FIFOS  per-channel full flag.
- fifo_data  out  NUM_FIFOS*FIFO_DATA_WIDTH  flattened; channel i occupies [i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH].
- pkt_done  out  NUM_FIFOS  one-cycle pulse when channel i's tlast beat is written.
- drop_count  out  CNT_WIDTH  saturating count of dropped packets.
- routing_error  out  1  sticky flag; set on any invalid tdest; cleared only by rst.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State IDLE, hold_valid=0, fifo_wren=0, pkt_done=0, drop_count=0, routing_error=0, fifo_data=0.
  - SRC_AXIS_tready=0 while rst is high.
- Holding register: one entry containing data, channel and last.
- Handshake:
  - SRC_AXIS_tready = !rst && (state==DROP || !hold_valid || hold_write).
  - hold_write = hold_valid && !fifo_full[hold_ch].
  - Full throughput: one beat per cycle when the target channel is not full.
- Output:
  - fifo_wren[i] = hold_valid && hold_ch==i && !fifo_full[i]. Combinational from fifo_full; at most one bit set.
  - fifo_data for every channel is driven from the holding register data, FIFO_DATA_WIDTH LSBs.
- Latency: a beat accepted in cycle N appears on fifo_wren/fifo_data in cycle N+1 if the target channel is not full. Otherwise it is held, unchanged, until the full flag clears.
- State machine:
  - IDLE: on an accepted beat, valid tdest -> latch ch=tdest and load the holding register. If that beat has tlast, stay IDLE (single-beat packet); else go to ROUTE.
  - IDLE, invalid tdest, DROP_INVALID=1: set routing_error and discard the beat. If tlast, increment drop_count and stay IDLE; else go to DROP.
  - IDLE, invalid tdest, DROP_INVALID=0: tready is forced 0 while tvalid && invalid tdest; set routing_error.
  - ROUTE: every accepted beat goes to the latched ch; tdest changes mid-packet are ignored. An accepted tlast beat returns to IDLE.
  - DROP: tready=1 and beats are discarded. An accepted tlast beat increments drop_count and returns to IDLE.
- pkt_done[i] is a registered pulse in the cycle after the holding register writes a last beat to channel i.
- drop_count saturates at all-ones with no wrap.
- Boundary conditions:
  - Target full with the holding register occupied: tready=0, no beat lost, holding register unchanged.
  - Full deasserting in the same cycle as a new tvalid: the write and the new accept occur in the same cycle.
  - Back-to-back packets to different channels: no bubble. The new tdest is sampled while the previous last beat drains.
  - Reset mid-packet: the holding register contents are discarded; the next beat is treated as a packet start.
- NUM_FIFOS=1: every valid tdest is 0; all other tdest values are invalid.

Test Plan:
- Reset, then a 4-beat packet with tdest=2, data 0xA0..0xA3, all FIFOs empty -> fifo_wren[2] pulses on 4 consecutive cycles starting one cycle after the first accept, data 0xA0..0xA3 in order; pkt_done[2] pulses once; tready stays high.
- 3-beat packet to tdest=1 with tdest changed to 3 on beat 2 -> all 3 beats are written to channel 1; fifo_wren[3] never asserts.
- Packet to tdest=0 with fifo_full[0] held high for 5 cycles after beat 1 -> tready is low for exactly those cycles; beats 0..3 arrive intact with no duplicates.
- DROP_INVALID=1, 5-beat packet with tdest=7, NUM_FIFOS=4 -> tready=1 throughout; no fifo_wren; drop_count=1; routing_error=1. A following packet to tdest=1 routes normally.
- DROP_INVALID=0, tdest=5 -> tready stays 0 for 20 cycles; routing_error=1; drop_count=0.
- Reset asserted on beat 2 of a 6-beat packet -> outputs return to reset values immediately. A new packet to tdest=3 after deassert routes correctly; pkt_done counts only the new packet.

Source files
------------

// File: rtl/mm2s_packet_router.sv
// mm2s_packet_router
// Registered, packet-aware router between the MCDMA mm2s AXI-Stream master
// and the per-accelerator input FIFOs. tdest is captured on the first beat
// of each packet and every beat up to tlast goes to that channel. Packets
// with an out-of-range tdest are either drained and counted, or stalled.

module mm2s_packet_router #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int NUM_FIFOS       = 4,
    parameter bit DROP_INVALID    = 1'b1,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [AXIS_DATA_WIDTH-1:0]           SRC_AXIS_tdata,
    input  logic [AXIS_DEST_WIDTH-1:0]           SRC_AXIS_tdest,
    input  logic                                 SRC_AXIS_tlast,
    input  logic                                 SRC_AXIS_tvalid,
    output logic                                 SRC_AXIS_tready,
    output logic [NUM_FIFOS-1:0]                 fifo_wren,
    input  logic [NUM_FIFOS-1:0]                 fifo_full,
    output logic [NUM_FIFOS*FIFO_DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_FIFOS-1:0]                 pkt_done,
    output logic [CNT_WIDTH-1:0]                 drop_count,
    output logic                                 routing_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUTE,
        S_DROP
    } state_t;

    state_t                     state;
    logic [AXIS_DEST_WIDTH-1:0] route_ch;

    // Single-entry holding register between the stream and the sinks.
    logic                       hold_valid;
    logic                       hold_last;
    logic [AXIS_DEST_WIDTH-1:0] hold_ch;
    logic [FIFO_DATA_WIDTH-1:0] hold_data;

    logic dest_invalid;
    logic stall_invalid;
    logic hold_write;
    logic accept;

    // A tdest at or beyond NUM_FIFOS has no sink behind it.
    assign dest_invalid = 32'(SRC_AXIS_tdest) >= NUM_FIFOS;

    // In stall mode an invalid packet start is refused rather than drained.
    assign stall_invalid = !DROP_INVALID && (state == S_IDLE)
                           && SRC_AXIS_tvalid && dest_invalid;

    // Per-channel write strobe straight from the full flags, so a full flag
    // that clears is acted on in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_FIFOS; i++) begin
            fifo_wren[i] = hold_valid && (hold_ch == AXIS_DEST_WIDTH'(i))
                           && !fifo_full[i];
        end
    end

    assign hold_write = |fifo_wren;

    // NOTE: tready is gated by rst directly so it drops the instant reset
    // asserts, not one edge later.
    assign SRC_AXIS_tready = !rst && !stall_invalid
                             && ((state == S_DROP) || !hold_valid || hold_write);

    assign accept = SRC_AXIS_tvalid && SRC_AXIS_tready;

    // Every sink sees the holding register; only the wren bit selects.
    always_comb begin
        for (int i = 0; i < NUM_FIFOS; i++) begin
            fifo_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] = hold_data;
        end
    end

    // Packet FSM, holding register, completion pulses and drop bookkeeping.
    // NOTE: all state here uses non-blocking assignments; a later assignment
    // in the same cycle (load after drain) deliberately overrides an earlier one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            route_ch      <= '0;
            hold_valid    <= 1'b0;
            hold_last     <= 1'b0;
            hold_ch       <= '0;
            hold_data     <= '0;
            pkt_done      <= '0;
            drop_count    <= '0;
            routing_error <= 1'b0;
        end else begin
            pkt_done <= (hold_write && hold_last) ? fifo_wren : '0;

            if (hold_write) begin
                hold_valid <= 1'b0;
            end

            if ((state == S_IDLE) && SRC_AXIS_tvalid && dest_invalid) begin
                routing_error <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!dest_invalid) begin
                            route_ch   <= SRC_AXIS_tdest;
                            hold_valid <= 1'b1;
                            hold_ch    <= SRC_AXIS_tdest;
                            hold_data  <= SRC_AXIS_tdata[FIFO_DATA_WIDTH-1:0];
                            hold_last  <= SRC_AXIS_tlast;
                            if (!SRC_AXIS_tlast) begin
                                state <= S_ROUTE;
                            end
                        end else if (SRC_AXIS_tlast) begin
                            if (drop_count != '1) begin
                                drop_count <= drop_count + 1'b1;
                            end
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end

                S_ROUTE: begin
                    if (accept) begin
                        hold_valid <= 1'b1;
                        hold_ch    <= route_ch;
                        hold_data  <= SRC_AXIS_tdata[FIFO_DATA_WIDTH-1:0];
                        hold_last  <= SRC_AXIS_tlast;
                        if (SRC_AXIS_tlast) begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_DROP: begin
                    if (accept && SRC_AXIS_tlast) begin
                        if (drop_count != '1) begin
                            drop_count <= drop_count + 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm2s_packet_router.sv
// Self-checking bench for mm2s_packet_router: a per-cycle vector table for
// routing, back-pressure and draining, plus hand sequences for counter
// saturation, stall mode and reset mid-packet.

module tb_mm2s_packet_router;

    localparam int DW = 32;
    localparam int NF = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;

    // Drain-mode DUT (small counter so saturation is reachable)
    logic [DW-1:0]   tdata;
    logic [3:0]      tdest;
    logic            tlast;
    logic            tvalid;
    logic            tready;
    logic [NF-1:0]   wren;
    logic [NF-1:0]   full;
    logic [NF*DW-1:0] fdata;
    logic [NF-1:0]   done;
    logic [CW-1:0]   drops;
    logic            err;

    // Stall-mode DUT
    logic [DW-1:0]   tdata0;
    logic [3:0]      tdest0;
    logic            tlast0;
    logic            tvalid0;
    logic            tready0;
    logic [NF-1:0]   wren0;
    logic [NF-1:0]   full0;
    logic [NF*DW-1:0] fdata0;
    logic [NF-1:0]   done0;
    logic [15:0]     drops0;
    logic            err0;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mm2s_packet_router #(.NUM_FIFOS(NF), .DROP_INVALID(1'b1), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .SRC_AXIS_tdata(tdata), .SRC_AXIS_tdest(tdest), .SRC_AXIS_tlast(tlast),
        .SRC_AXIS_tvalid(tvalid), .SRC_AXIS_tready(tready),
        .fifo_wren(wren), .fifo_full(full), .fifo_data(fdata),
        .pkt_done(done), .drop_count(drops), .routing_error(err)
    );

    mm2s_packet_router #(.NUM_FIFOS(NF), .DROP_INVALID(1'b0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst),
        .SRC_AXIS_tdata(tdata0), .SRC_AXIS_tdest(tdest0), .SRC_AXIS_tlast(tlast0),
        .SRC_AXIS_tvalid(tvalid0), .SRC_AXIS_tready(tready0),
        .fifo_wren(wren0), .fifo_full(full0), .fifo_data(fdata0),
        .pkt_done(done0), .drop_count(drops0), .routing_error(err0)
    );

    typedef struct {
        logic          v;
        logic [3:0]    dest;
        logic [DW-1:0] data;
        logic          last;
        logic [NF-1:0] full;
        logic          rdy;
        logic [NF-1:0] wren;
        logic [DW-1:0] wdata;
        logic [NF-1:0] done;
        logic [CW-1:0] drop;
        logic          err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic v, input logic [3:0] dest, input logic [DW-1:0] data,
                                input logic last, input logic [NF-1:0] f, input logic rdy,
                                input logic [NF-1:0] we, input logic [DW-1:0] wd,
                                input logic [NF-1:0] dn, input logic [CW-1:0] dr, input logic er);
        vec_t r;
        r.v = v; r.dest = dest; r.data = data; r.last = last; r.full = f;
        r.rdy = rdy; r.wren = we; r.wdata = wd; r.done = dn; r.drop = dr; r.err = er;
        vecs.push_back(r);
    endfunction

    // Apply inputs 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [3:0] dest, input logic [DW-1:0] data,
                         input logic last, input logic [NF-1:0] f);
        @(posedge clk);
        #1;
        tvalid = v; tdest = dest; tdata = data; tlast = last; full = f;
    endtask

    task automatic check_data(input string name, input logic [NF-1:0] we, input logic [DW-1:0] exp);
        for (int i = 0; i < NF; i++) begin
            if (we[i]) check(name, 64'(fdata[i*DW +: DW]), 64'(exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       hi_cnt;
        int       done_cnt [NF];
        logic [3:0] c1 = 4'b0010, c2 = 4'b0100, c0 = 4'b0001, c3 = 4'b1000;

        rst = 1'b1;
        tvalid = 0; tdest = 0; tdata = 0; tlast = 0; full = 0;
        tvalid0 = 0; tdest0 = 0; tdata0 = 0; tlast0 = 0; full0 = 0;

        // ---- vector table: one row per cycle ----
        //   v  dest  data        last full  | rdy wren wdata    done drop err
        // 4-beat packet to ch2
        add(1, 2, 32'hA0, 0, 0,    1, 0,  0,      0,  0, 0);
        add(1, 2, 32'hA1, 0, 0,    1, c2, 32'hA0, 0,  0, 0);
        add(1, 2, 32'hA2, 0, 0,    1, c2, 32'hA1, 0,  0, 0);
        add(1, 2, 32'hA3, 1, 0,    1, c2, 32'hA2, 0,  0, 0);
        // back-to-back 3-beat packet to ch1, tdest changes to 3 mid-packet
        add(1, 1, 32'hB0, 0, 0,    1, c2, 32'hA3, 0,  0, 0);
        add(1, 3, 32'hB1, 0, 0,    1, c1, 32'hB0, c2, 0, 0);
        add(1, 1, 32'hB2, 1, 0,    1, c1, 32'hB1, 0,  0, 0);
        add(0, 0, 32'h0,  0, 0,    1, c1, 32'hB2, 0,  0, 0);
        add(0, 0, 32'h0,  0, 0,    1, 0,  0,      c1, 0, 0);
        // packet to ch0 with full[0] high for 5 cycles after beat 0
        add(1, 0, 32'hC0, 0, 0,    1, 0,  0,      0,  0, 0);
        for (int k = 0; k < 5; k++)
            add(1, 0, 32'hC1, 0, c0, 0, 0,  0,      0,  0, 0);
        add(1, 0, 32'hC1, 0, 0,    1, c0, 32'hC0, 0,  0, 0);
        add(1, 0, 32'hC2, 0, 0,    1, c0, 32'hC1, 0,  0, 0);
        add(1, 0, 32'hC3, 1, 0,    1, c0, 32'hC2, 0,  0, 0);
        add(0, 0, 32'h0,  0, 0,    1, c0, 32'hC3, 0,  0, 0);
        add(0, 0, 32'h0,  0, 0,    1, 0,  0,      c0, 0, 0);
        // 5-beat packet to invalid tdest 7 is drained
        add(1, 7, 32'hD0, 0, 0,    1, 0,  0,      0,  0, 0);
        add(1, 7, 32'hD1, 0, 0,    1, 0,  0,      0,  0, 1);
        add(1, 2, 32'hD2, 0, 0,    1, 0,  0,      0,  0, 1);
        add(1, 7, 32'hD3, 0, 0,    1, 0,  0,      0,  0, 1);
        add(1, 7, 32'hD4, 1, 0,    1, 0,  0,      0,  0, 1);
        // following single-beat packet to ch1 routes normally
        add(1, 1, 32'hE0, 1, 0,    1, 0,  0,      0,  1, 1);
        add(0, 0, 32'h0,  0, 0,    1, c1, 32'hE0, 0,  1, 1);
        add(0, 0, 32'h0,  0, 0,    1, 0,  0,      c1, 1, 1);

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", 64'(tready), 64'h0);
        check("rst_wren", 64'(wren), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_drop", 64'(drops), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_fdata", 64'(fdata[63:0]), 64'h0);
        check("rst_tready0", 64'(tready0), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- table-driven section ----
        foreach (vecs[n]) begin
            drive(vecs[n].v, vecs[n].dest, vecs[n].data, vecs[n].last, vecs[n].full);
            @(negedge clk);
            check($sformatf("v%0d_tready", n), 64'(tready), 64'(vecs[n].rdy));
            check($sformatf("v%0d_wren", n), 64'(wren), 64'(vecs[n].wren));
            check_data($sformatf("v%0d_data", n), vecs[n].wren, vecs[n].wdata);
            check($sformatf("v%0d_done", n), 64'(done), 64'(vecs[n].done));
            check($sformatf("v%0d_drop", n), 64'(drops), 64'(vecs[n].drop));
            check($sformatf("v%0d_err", n), 64'(err), 64'(vecs[n].err));
        end

        // ---- drop_count saturation: 8 more single-beat invalid packets ----
        hi_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 4'd9, 32'(k), 1, 0);
            @(negedge clk);
            if (tready && wren == 0) hi_cnt++;
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("sat_accept_cycles", 64'(hi_cnt), 64'd8);
        check("sat_drop_count", 64'(drops), 64'd7);

        // ---- stall mode: invalid tdest never accepted ----
        check("stall_err_before", 64'(err0), 64'h0);
        hi_cnt = 0;
        @(posedge clk);
        #1;
        tvalid0 = 1; tdest0 = 4'd5; tdata0 = 32'h55; tlast0 = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tready0) hi_cnt++;
        end
        check("stall_tready_high_cycles", 64'(hi_cnt), 64'd0);
        check("stall_err", 64'(err0), 64'h1);
        check("stall_drop", 64'(drops0), 64'h0);
        check("stall_wren", 64'(wren0), 64'h0);
        @(posedge clk);
        #1;
        tvalid0 = 0;

        // ---- reset mid-packet ----
        drive(1, 2, 32'hF0, 0, 0);
        drive(1, 2, 32'hF1, 0, 0);
        drive(1, 2, 32'hF2, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tready", 64'(tready), 64'h0);
        check("midrst_wren", 64'(wren), 64'h0);
        check("midrst_fdata", 64'(fdata), 64'h0);
        check("midrst_drop", 64'(drops), 64'h0);
        check("midrst_err", 64'(err), 64'h0);
        check("midrst_done", 64'(done), 64'h0);
        tvalid = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (done_cnt[i]) done_cnt[i] = 0;
        drive(1, 3, 32'h30, 0, 0);
        @(negedge clk);
        check("post_b0_tready", 64'(tready), 64'h1);
        check("post_b0_wren", 64'(wren), 64'h0);
        drive(1, 3, 32'h31, 1, 0);
        @(negedge clk);
        check("post_b1_wren", 64'(wren), 64'(c3));
        check_data("post_b1_data", wren, 32'h30);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("post_b2_wren", 64'(wren), 64'(c3));
        check_data("post_b2_data", wren, 32'h31);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NF; i++) if (done[i]) done_cnt[i]++;
            @(negedge clk);
        end
        for (int i = 0; i < NF; i++)
            check($sformatf("post_done_count_ch%0d", i), 64'(done_cnt[i]), (i == 3) ? 64'd1 : 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
